mmio_mem: RTL and testbench

Parametrised data memory with memory-mapped I/O ports, the next generation of the CPU's `mem` block. It decodes the instruction's top three bits, services reads and writes on the shared bidirectional data bus and routes the highest addresses to handshaked input/output port registers and a status register; all remaining addresses are RAM. Reads are registered with one-cycle latency. A debug tap exposes one RAM word for waveform viewing.

---
 rtl/mmio_mem_pkg.sv | 27 ++
 rtl/mmio_in_port.sv | 43 ++++
 rtl/mmio_mem.sv | 140 ++++++++++++++
 tb/tb_mmio_mem.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_mem_pkg.sv
// Shared opcodes and address-map helpers for the memory-mapped data memory.
package mmio_mem_pkg;

    localparam logic [2:0] OP_READ  = 3'b010;
    localparam logic [2:0] OP_WRITE = 3'b100;

    // First output-port address: output ports occupy the top of the map.
    function automatic int unsigned out_base(int unsigned aw, int unsigned n_out);
        return (32'd1 << aw) - n_out;
    endfunction

    // First input-port address: input ports sit directly below the output ports.
    function automatic int unsigned in_base(int unsigned aw, int unsigned n_in, int unsigned n_out);
        return (32'd1 << aw) - n_out - n_in;
    endfunction

    // Status register sits directly below the input ports; RAM is everything below it.
    function automatic int unsigned status_addr(int unsigned aw, int unsigned n_in, int unsigned n_out);
        return in_base(aw, n_in, n_out) - 1;
    endfunction

    // Sticky overflow flag lives in the top bit of the status word.
    function automatic int unsigned ovf_bit(int unsigned dw);
        return dw - 1;
    endfunction

endpackage

// File: rtl/mmio_in_port.sv
// One-deep valid/ready input buffer; emptied by a pop from the bus side.
module mmio_in_port #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              pop,
    output logic              in_ready,
    output logic [DATA_W-1:0] buf_data
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Load only when empty, pop only when full: a refill cannot share the popping edge.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (!full_q && in_valid) begin
            full_d = 1'b1;
            data_d = in_data;
        end else if (full_q && pop) begin
            full_d = 1'b0;
        end
    end

    // Buffer state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign in_ready = ~full_q;
    assign buf_data = full_q ? data_q : '0;

endmodule

// File: rtl/mmio_mem.sv
// Data memory with memory-mapped input/output ports, a status register and a
// registered, bus-driving read path.
module mmio_mem
    import mmio_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_W-1:0]       a_bus,
    input  logic [7:0]              instruction,
    input  logic                    dbus_sel,
    inout  wire  [DATA_W-1:0]       d_bus,
    input  logic [N_IN*DATA_W-1:0]  in_data,
    input  logic [N_IN-1:0]         in_valid,
    output logic [N_IN-1:0]         in_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    input  logic [ADDR_W-1:0]       view_addr,
    output logic [DATA_W-1:0]       view_mem
);

    localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(status_addr(ADDR_W, N_IN, N_OUT));
    localparam logic [ADDR_W-1:0] IN_A     = ADDR_W'(in_base(ADDR_W, N_IN, N_OUT));
    localparam logic [ADDR_W-1:0] OUT_A    = ADDR_W'(out_base(ADDR_W, N_OUT));
    localparam int unsigned       OVF_BIT  = ovf_bit(DATA_W);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic [DATA_W-1:0]       rd_data_q, rd_data_d;
    logic                    drive_q, drive_d;
    logic [N_OUT*DATA_W-1:0] out_data_q, out_data_d;
    logic [N_OUT-1:0]        out_valid_q, out_valid_d;
    logic                    ovf_q, ovf_d;

    logic [2:0]             op;
    logic                   rd_acc, wr_acc, is_ram, ram_we;
    logic [DATA_W-1:0]      rd_val, status_word;
    logic [N_IN-1:0]        pop;
    logic [N_IN*DATA_W-1:0] in_buf;
    logic                   unused_instr;

    assign op           = instruction[7:5];
    assign unused_instr = ^instruction[4:0];

    for (genvar g = 0; g < N_IN; g++) begin : g_in
        mmio_in_port #(.DATA_W(DATA_W)) u_in (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_data  (in_data[g*DATA_W +: DATA_W]),
            .in_valid (in_valid[g]),
            .pop      (pop[g]),
            .in_ready (in_ready[g]),
            .buf_data (in_buf[g*DATA_W +: DATA_W])
        );
    end

    // Decode, read mux and next-state for the read register, output ports and overflow.
    // Accept flags use if-statements so an X/Z opcode or dbus_sel falls to no-op.
    always_comb begin
        rd_acc = 1'b0;
        wr_acc = 1'b0;
        if (op == OP_READ && dbus_sel == 1'b0) rd_acc = 1'b1;
        if (op == OP_WRITE && dbus_sel == 1'b1) wr_acc = 1'b1;

        is_ram = (a_bus < STATUS_A);

        status_word = '0;
        for (int unsigned k = 0; k < N_IN; k++) status_word[k] = ~in_ready[k];
        for (int unsigned k = 0; k < N_OUT; k++) status_word[N_IN + k] = out_valid_q[k];
        status_word[OVF_BIT] = ovf_q;

        rd_val = '0;
        if (is_ram) rd_val = mem_q[a_bus];
        else if (a_bus == STATUS_A) rd_val = status_word;
        for (int unsigned k = 0; k < N_IN; k++)
            if (a_bus == IN_A + ADDR_W'(k)) rd_val = in_buf[k*DATA_W +: DATA_W];
        for (int unsigned k = 0; k < N_OUT; k++)
            if (a_bus == OUT_A + ADDR_W'(k)) rd_val = out_data_q[k*DATA_W +: DATA_W];

        drive_d   = rd_acc;
        rd_data_d = rd_acc ? rd_val : rd_data_q;

        pop = '0;
        for (int unsigned k = 0; k < N_IN; k++)
            pop[k] = rd_acc && (a_bus == IN_A + ADDR_W'(k)) && !in_ready[k];

        ram_we = wr_acc && is_ram;

        ovf_d = ovf_q;
        if (rd_acc && a_bus == STATUS_A) ovf_d = 1'b0;

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (wr_acc && a_bus == OUT_A + ADDR_W'(k)) begin
                if (!out_valid_q[k] || out_ready[k]) begin
                    out_data_d[k*DATA_W +: DATA_W] = d_bus;
                    out_valid_d[k] = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (out_valid_q[k] && out_ready[k]) begin
                out_valid_d[k] = 1'b0;
            end
        end
    end

    // Control and port registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q   <= '0;
            drive_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            rd_data_q   <= rd_data_d;
            drive_q     <= drive_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // RAM array: contents are not reset, writes are suppressed while in reset.
    always_ff @(posedge clk) begin
        if (rst_n && ram_we) mem_q[a_bus] <= d_bus;
    end

    assign d_bus     = drive_q ? rd_data_q : 'z;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign view_mem  = (view_addr < STATUS_A) ? mem_q[view_addr] : '0;

endmodule

// File: tb/tb_mmio_mem.sv
// Self-checking bench for mmio_mem with a behavioural model of the address map.
module tb_mmio_mem;

    localparam int A    = 1 << 5;
    localparam int STAT = A - 2 - 2 - 1;
    localparam int IN0  = A - 2 - 2;
    localparam int OUT0 = A - 2;
    localparam logic [2:0] RD  = 3'b010;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] NOP = 3'b000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  a_bus, view_addr;
    logic [7:0]  instruction;
    logic        dbus_sel;
    tri1  [7:0]  d_bus;
    logic [15:0] in_data, out_data;
    logic [1:0]  in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  view_mem;
    logic        tb_den;
    logic [7:0]  tb_dq;

    assign d_bus = tb_den ? tb_dq : 'z;

    always #5 clk = ~clk;

    mmio_mem #(.DATA_W(8), .ADDR_W(5), .N_IN(2), .N_OUT(2)) dut (
        .clk(clk), .rst_n(rst_n), .a_bus(a_bus), .instruction(instruction),
        .dbus_sel(dbus_sel), .d_bus(d_bus), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .view_addr(view_addr), .view_mem(view_mem)
    );

    // Model state
    logic [7:0]  m_mem [A];
    bit          m_known [A];
    logic [1:0]  m_in_full, m_out_valid;
    logic [15:0] m_in_data, m_out_data;
    logic        m_ovf, m_drive, m_rdata_ok;
    logic [7:0]  m_rdata;
    logic [7:0]  exp_bus, exp_view;
    bit          exp_bus_ok, exp_view_ok;

    int checks = 0;
    int failures = 0;

    task automatic one_cycle(input logic rst, input logic [2:0] op, input logic sel,
                             input logic [4:0] addr, input logic [7:0] wd,
                             input logic [1:0] iv, input logic [15:0] id,
                             input logic [1:0] ordy, input logic [4:0] va);
        logic rd, wr, drop;
        logic [7:0] rv;
        bit rv_ok;
        rst_n = rst; instruction = {op, 5'($urandom)}; dbus_sel = sel; a_bus = addr;
        tb_den = sel; tb_dq = wd; in_valid = iv; in_data = id; out_ready = ordy; view_addr = va;

        rd = (op == RD) && !sel;
        wr = (op == WR) && sel;
        rv = '0; rv_ok = 1;
        if (int'(addr) < STAT) begin
            rv = m_mem[addr]; rv_ok = m_known[addr];
        end else if (int'(addr) == STAT) begin
            rv = {m_ovf, 3'b000, m_out_valid, m_in_full};
        end else if (int'(addr) < OUT0) begin
            rv = m_in_full[int'(addr) - IN0] ? m_in_data[(int'(addr) - IN0)*8 +: 8] : 8'h00;
        end else begin
            rv = m_out_data[(int'(addr) - OUT0)*8 +: 8];
        end

        if (!rst) begin
            m_in_full = '0; m_out_valid = '0; m_out_data = '0; m_ovf = 0;
            m_drive = 0; m_rdata = '0; m_rdata_ok = 1;
        end else begin
            m_drive = rd;
            if (rd) begin m_rdata = rv; m_rdata_ok = rv_ok; end
            if (wr && int'(addr) < STAT) begin m_mem[addr] = wd; m_known[addr] = 1; end
            for (int k = 0; k < 2; k++) begin
                if (m_in_full[k] && rd && int'(addr) == IN0 + k) m_in_full[k] = 0;
                else if (!m_in_full[k] && iv[k]) begin
                    m_in_full[k] = 1; m_in_data[k*8 +: 8] = id[k*8 +: 8];
                end
            end
            drop = 0;
            for (int k = 0; k < 2; k++) begin
                if (wr && int'(addr) == OUT0 + k) begin
                    if (!m_out_valid[k] || ordy[k]) begin
                        m_out_data[k*8 +: 8] = wd; m_out_valid[k] = 1;
                    end else drop = 1;
                end else if (m_out_valid[k] && ordy[k]) m_out_valid[k] = 0;
            end
            if (drop) m_ovf = 1;
            else if (rd && int'(addr) == STAT) m_ovf = 0;
        end

        exp_bus    = m_drive ? m_rdata : 8'hFF;
        exp_bus_ok = !m_drive || m_rdata_ok;
        exp_view   = (int'(va) < STAT) ? m_mem[va] : 8'h00;
        exp_view_ok = (int'(va) >= STAT) || m_known[va];

        @(posedge clk);
        #1 tb_den = 0;
        #1;
    endtask

    // Inserts a turnaround cycle when the DUT is still driving the bus.
    task automatic step(input logic [2:0] op, input logic sel, input logic [4:0] addr,
                        input logic [7:0] wd, input logic [1:0] iv, input logic [15:0] id,
                        input logic [1:0] ordy, input logic [4:0] va);
        if (m_drive && sel) one_cycle(1, NOP, 0, 5'd0, 8'h00, iv, id, ordy, va);
        one_cycle(1, op, sel, addr, wd, iv, id, ordy, va);
    endtask

    task automatic test_reset();
        one_cycle(0, NOP, 0, 5'd0, 8'h00, 2'b00, 16'h0, 2'b00, 5'd0);
        one_cycle(0, RD, 0, 5'd0, 8'h00, 2'b00, 16'h0, 2'b00, 5'd0);
        checks++; if (in_ready !== 2'b11) begin failures++; $display("FAIL reset_in_ready got=%b exp=11", in_ready); end
        checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
        checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        checks++; if (d_bus !== 8'hFF) begin failures++; $display("FAIL reset_d_bus got=%h exp=released", d_bus); end
    endtask

    task automatic test_ram();
        logic [4:0] ad;
        step(WR, 1, 5'd3, 8'hA5, 2'b00, 16'h0, 2'b00, 5'd3);
        step(RD, 0, 5'd3, 8'h00, 2'b00, 16'h0, 2'b00, 5'd3);
        checks++; if (d_bus !== 8'hA5) begin failures++; $display("FAIL ram_read got=%h exp=a5", d_bus); end
        step(NOP, 0, 5'd3, 8'h00, 2'b00, 16'h0, 2'b00, 5'd3);
        checks++; if (d_bus !== 8'hFF) begin failures++; $display("FAIL ram_release got=%h exp=released", d_bus); end
        checks++; if (view_mem !== 8'hA5) begin failures++; $display("FAIL view_mem got=%h exp=a5", view_mem); end
        for (int i = 0; i < STAT; i++)
            step(WR, 1, 5'(i), 8'($urandom_range(0, 254)), 2'b00, 16'h0, 2'b00, 5'(i));
        for (int i = 0; i < 20; i++) begin
            ad = 5'($urandom_range(0, STAT - 1));
            step(RD, 0, ad, 8'h00, 2'b00, 16'h0, 2'b00, 5'($urandom));
            checks++; if (d_bus !== exp_bus) begin failures++; $display("FAIL ram_rand addr=%0d got=%h exp=%h", ad, d_bus, exp_bus); end
            checks++; if (view_mem !== exp_view) begin failures++; $display("FAIL view_rand got=%h exp=%h", view_mem, exp_view); end
        end
    endtask

    task automatic test_in_port();
        step(NOP, 0, 5'd0, 8'h00, 2'b01, 16'h003C, 2'b00, 5'd0);
        checks++; if (in_ready !== 2'b10) begin failures++; $display("FAIL in_load_ready got=%b exp=10", in_ready); end
        step(RD, 0, 5'(STAT), 8'h00, 2'b00, 16'h0, 2'b00, 5'd0);
        checks++; if (d_bus[0] !== 1'b1) begin failures++; $display("FAIL in_status_bit0 got=%b exp=1", d_bus[0]); end
        step(RD, 0, 5'(IN0), 8'h00, 2'b00, 16'h0, 2'b00, 5'd0);
        checks++; if (d_bus !== 8'h3C) begin failures++; $display("FAIL in_pop_data got=%h exp=3c", d_bus); end
        checks++; if (in_ready !== 2'b11) begin failures++; $display("FAIL in_pop_ready got=%b exp=11", in_ready); end
        step(RD, 0, 5'(IN0), 8'h00, 2'b00, 16'h0, 2'b00, 5'd0);
        checks++; if (d_bus !== 8'h00) begin failures++; $display("FAIL in_empty_read got=%h exp=00", d_bus); end
    endtask

    task automatic test_out_port();
        step(WR, 1, 5'(OUT0), 8'h11, 2'b00, 16'h0, 2'b00, 5'd0);
        checks++; if (out_valid[0] !== 1'b1) begin failures++; $display("FAIL out_valid0 got=%b exp=1", out_valid[0]); end
        step(WR, 1, 5'(OUT0), 8'h22, 2'b00, 16'h0, 2'b00, 5'd0);
        checks++; if (out_data[7:0] !== 8'h11) begin failures++; $display("FAIL out_drop_data got=%h exp=11", out_data[7:0]); end
        step(RD, 0, 5'(STAT), 8'h00, 2'b00, 16'h0, 2'b00, 5'd0);
        checks++; if (d_bus !== 8'h84) begin failures++; $display("FAIL status_ovf got=%h exp=84", d_bus); end
        step(RD, 0, 5'(STAT), 8'h00, 2'b00, 16'h0, 2'b00, 5'd0);
        checks++; if (d_bus !== 8'h04) begin failures++; $display("FAIL status_clear got=%h exp=04", d_bus); end
        step(RD, 0, 5'(OUT0), 8'h00, 2'b00, 16'h0, 2'b00, 5'd0);
        checks++; if (d_bus !== 8'h11) begin failures++; $display("FAIL out_readback got=%h exp=11", d_bus); end
    endtask

    task automatic test_handshake_write();
        step(WR, 1, 5'(OUT0 + 1), 8'h77, 2'b00, 16'h0, 2'b00, 5'd0);
        step(WR, 1, 5'(OUT0 + 1), 8'h55, 2'b00, 16'h0, 2'b10, 5'd0);
        checks++; if (out_valid[1] !== 1'b1) begin failures++; $display("FAIL hs_valid got=%b exp=1", out_valid[1]); end
        checks++; if (out_data[15:8] !== 8'h55) begin failures++; $display("FAIL hs_data got=%h exp=55", out_data[15:8]); end
        step(RD, 0, 5'(STAT), 8'h00, 2'b00, 16'h0, 2'b00, 5'd0);
        checks++; if (d_bus !== 8'h0C) begin failures++; $display("FAIL hs_status got=%h exp=0c", d_bus); end
        step(NOP, 0, 5'd0, 8'h00, 2'b00, 16'h0, 2'b11, 5'd0);
        checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL hs_drain got=%b exp=00", out_valid); end
    endtask

    task automatic test_noop();
        logic [2:0] ops [4] = '{3'b111, RD, WR, 3'b000};
        logic       sels [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        step(WR, 1, 5'd5, 8'h5A, 2'b00, 16'h0, 2'b00, 5'd5);
        for (int i = 0; i < 4; i++) begin
            step(ops[i], sels[i], 5'd5, 8'hC3, 2'b00, 16'h0, 2'b00, 5'd5);
            checks++; if (d_bus !== 8'hFF) begin failures++; $display("FAIL noop_bus%0d got=%h exp=released", i, d_bus); end
        end
        checks++; if (view_mem !== 8'h5A) begin failures++; $display("FAIL noop_view got=%h exp=5a", view_mem); end
        step(RD, 0, 5'd5, 8'h00, 2'b00, 16'h0, 2'b00, 5'd5);
        checks++; if (d_bus !== 8'h5A) begin failures++; $display("FAIL noop_ram got=%h exp=5a", d_bus); end
    endtask

    task automatic test_reset_mid();
        step(WR, 1, 5'(OUT0), 8'h99, 2'b11, 16'hBEEF, 2'b00, 5'd0);
        step(RD, 0, 5'd1, 8'h00, 2'b00, 16'h0, 2'b00, 5'd0);
        one_cycle(0, RD, 0, 5'd2, 8'h00, 2'b00, 16'h0, 2'b00, 5'd0);
        checks++; if (d_bus !== 8'hFF) begin failures++; $display("FAIL rstmid_bus got=%h exp=released", d_bus); end
        checks++; if (in_ready !== 2'b11) begin failures++; $display("FAIL rstmid_ready got=%b exp=11", in_ready); end
        checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL rstmid_valid got=%b exp=00", out_valid); end
        step(RD, 0, 5'(IN0 + 1), 8'h00, 2'b00, 16'h0, 2'b00, 5'd0);
        checks++; if (d_bus !== 8'h00) begin failures++; $display("FAIL rstmid_inbuf got=%h exp=00", d_bus); end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic sel;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0, 1: begin op = RD;  sel = 0; end
                2, 3: begin op = WR;  sel = 1; end
                4:    begin op = 3'($urandom); sel = 1'($urandom); end
                default: begin op = NOP; sel = 0; end
            endcase
            step(op, sel, 5'($urandom), 8'($urandom_range(0, 254)), 2'($urandom),
                 16'($urandom), 2'($urandom), 5'($urandom));
            if (exp_bus_ok) begin
                checks++; if (d_bus !== exp_bus) begin failures++; $display("FAIL rand_bus i=%0d got=%h exp=%h", i, d_bus, exp_bus); end
            end
            checks++; if (in_ready !== ~m_in_full) begin failures++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, in_ready, ~m_in_full); end
            checks++; if (out_valid !== m_out_valid) begin failures++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, out_valid, m_out_valid); end
            checks++; if (out_data !== m_out_data) begin failures++; $display("FAIL rand_odata i=%0d got=%h exp=%h", i, out_data, m_out_data); end
            if (exp_view_ok) begin
                checks++; if (view_mem !== exp_view) begin failures++; $display("FAIL rand_view i=%0d got=%h exp=%h", i, view_mem, exp_view); end
            end
        end
    endtask

    initial begin
        tb_den = 0; tb_dq = '0;
        m_drive = 0; m_rdata = '0; m_rdata_ok = 1; m_ovf = 0;
        m_in_full = '0; m_in_data = '0; m_out_valid = '0; m_out_data = '0;
        for (int i = 0; i < A; i++) begin m_known[i] = 0; m_mem[i] = '0; end
        test_reset();
        test_ram();
        test_in_port();
        test_out_port();
        test_handshake_write();
        test_noop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
